// File: rtl/sshr_pkg.sv
// +------------------------------------------------------------------+
// | sshr_pkg: shared types, defaults and shift-amount clamp for      |
// | the iterative arithmetic right shifter.                          |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

package sshr_pkg;

    localparam int DATAWIDTH_DEF = 32;
    localparam int STEP_DEF      = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Any amount of width-1 or more already yields all sign bits.
    function automatic int unsigned clamp_shift(input logic [63:0] amt,
                                                input int unsigned width);
        if (amt >= 64'(width - 1))
            return width - 1;
        return 32'(amt);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sshr_step.sv
// +------------------------------------------------------------------+
// | sshr_step: combinational arithmetic right shift by 0..STEP.      |
// | Config macro: SSHR_STICKY_EN adds the shifted-out OR output.     |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module sshr_step #(
    parameter int DATAWIDTH = 32,
    parameter int STEP      = 4,
    parameter int KW        = $clog2(STEP + 1)
) (
    input  logic [DATAWIDTH-1:0] d,
    input  logic [KW-1:0]        k,
`ifdef SSHR_STICKY_EN
    output logic                 lost,
`endif
    output logic [DATAWIDTH-1:0] q
);

    assign q = DATAWIDTH'($signed(d) >>> k);

`ifdef SSHR_STICKY_EN
    logic [DATAWIDTH-1:0] low_mask;

    assign low_mask = ~({DATAWIDTH{1'b1}} << k);
    assign lost     = |(d & low_mask);
`endif

endmodule

`default_nettype wire

// File: rtl/sshr_iter.sv
// +------------------------------------------------------------------+
// | sshr_iter: iterative signed right shifter, up to STEP bits/clock |
// | with valid/ready handshakes. Config macro: SSHR_STICKY_EN.       |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module sshr_iter
    import sshr_pkg::*;
#(
    parameter int DATAWIDTH = DATAWIDTH_DEF,
    parameter int STEP      = STEP_DEF
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] sh_amt,
    output logic                 out_valid,
    input  logic                 out_ready,
`ifdef SSHR_STICKY_EN
    output logic                 sticky,
`endif
    output logic [DATAWIDTH-1:0] d
);

    localparam int RW = $clog2(DATAWIDTH);
    localparam int KW = $clog2(STEP + 1);

    state_t          state;
    logic [RW-1:0]   rem;
    logic [RW-1:0]   load_rem;
    logic [KW-1:0]   step_k;
    logic [RW-1:0]   rem_next;
    logic [DATAWIDTH-1:0] step_q;

    assign load_rem = RW'(clamp_shift(64'(sh_amt), DATAWIDTH));
    assign step_k   = (rem < RW'(STEP)) ? KW'(rem) : KW'(STEP);
    assign rem_next = rem - RW'(step_k);

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

`ifdef SSHR_STICKY_EN
    logic step_lost;

    sshr_step #(
        .DATAWIDTH (DATAWIDTH),
        .STEP      (STEP),
        .KW        (KW)
    ) u_step (
        .d    (d),
        .k    (step_k),
        .lost (step_lost),
        .q    (step_q)
    );

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            sticky <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            sticky <= 1'b0;
        end else if (state == SHIFT) begin
            sticky <= sticky | step_lost;
        end
    end
`else
    sshr_step #(
        .DATAWIDTH (DATAWIDTH),
        .STEP      (STEP),
        .KW        (KW)
    ) u_step (
        .d (d),
        .k (step_k),
        .q (step_q)
    );
`endif

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= IDLE;
            d     <= '0;
            rem   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        d     <= a;
                        rem   <= load_rem;
                        state <= (load_rem == '0) ? DONE : SHIFT;
                    end
                end
                SHIFT: begin
                    d   <= step_q;
                    rem <= rem_next;
                    if (rem_next == '0)
                        state <= DONE;
                end
                DONE: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
